// File: rtl/crossbar_scheduler.sv
// -----------------------------------------------------------------------------
// crossbar_scheduler
//
// Round-robin scheduler for a 4x4 cell switch. Matches the head cells of four
// show-ahead input FIFOs to four outputs, then spends one XFER cycle driving
// the output mux selects, popping the granted FIFOs and flagging valid results.
// A matching round therefore takes two cycles (ARB, XFER).
//
// Optional feature macro: SCHED_STATS_EN
//   When defined, adds four saturating per-output cell counters and a
//   stat_sel/stat_count read port. When undefined those ports do not exist.
//
// Ports
//   clk         in   1        system clock
//   reset       in   1        synchronous, active-high reset
//   empty       in   4        per-input FIFO empty flags (bit i = FIFO i)
//   head0..3    in   DATA_W   FIFO head cells; destination in [DEST_LSB+1:DEST_LSB]
//   rdreq       out  4        per-input FIFO pop (bit i = FIFO i)
//   sel0..3     out  3        mux select for output o (input index 0..3)
//   out_valid   out  4        bit o = output o carries a valid cell this cycle
//   busy        out  1        high during XFER
//   stat_sel    in   2        counter select           (SCHED_STATS_EN only)
//   stat_count  out  STAT_W   cells sent on stat_sel   (SCHED_STATS_EN only)
// -----------------------------------------------------------------------------
module crossbar_scheduler #(
  parameter int DATA_W   = 8,
  parameter int DEST_LSB = 0,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        empty,
  input  logic [DATA_W-1:0] head0,
  input  logic [DATA_W-1:0] head1,
  input  logic [DATA_W-1:0] head2,
  input  logic [DATA_W-1:0] head3,
  output logic [3:0]        rdreq,
  output logic [2:0]        sel0,
  output logic [2:0]        sel1,
  output logic [2:0]        sel2,
  output logic [2:0]        sel3,
  output logic [3:0]        out_valid,
  output logic              busy
`ifdef SCHED_STATS_EN
  ,
  input  logic [1:0]        stat_sel,
  output logic [STAT_W-1:0] stat_count
`endif
);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [3:0] r_rdreq;
  logic [3:0] r_out_valid;
  logic       r_busy;
  logic [2:0] r_sel      [4];
  logic [1:0] r_rr_ptr   [4];

  logic [3:0] w_rdreq_nxt;
  logic [3:0] w_out_valid_nxt;
  logic       w_busy_nxt;
  logic [2:0] w_sel_nxt  [4];
  logic [1:0] w_rr_nxt   [4];

  logic [1:0] w_dest     [4];   // destination of each head cell
  logic [3:0] w_req      [4];   // w_req[o][i]: input i requests output o
  logic [3:0] w_gnt_vld;        // output o has a grant this round
  logic [1:0] w_gnt_idx  [4];   // granted input for output o

  assign w_dest[0] = head0[DEST_LSB +: 2];
  assign w_dest[1] = head1[DEST_LSB +: 2];
  assign w_dest[2] = head2[DEST_LSB +: 2];
  assign w_dest[3] = head3[DEST_LSB +: 2];

  // Each non-empty input requests exactly one output, so the per-output
  // grants below can never collide on an input.
  always_comb begin
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 4; i++) begin
        w_req[o][i] = !empty[i] && (w_dest[i] == 2'(o));
      end
    end
  end

  // Per-output round-robin: first requester at or after the pointer wins.
  always_comb begin
    logic [1:0] cand;
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    cand = '0;
    for (int o = 0; o < 4; o++) begin
      w_gnt_vld[o] = 1'b0;
      w_gnt_idx[o] = r_rr_ptr[o];
      for (int k = 0; k < 4; k++) begin
        cand = r_rr_ptr[o] + 2'(k);
        if (!w_gnt_vld[o] && w_req[o][cand]) begin
          w_gnt_vld[o] = 1'b1;
          w_gnt_idx[o] = cand;
        end
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_rdreq_nxt     = '0;
    w_out_valid_nxt = '0;
    w_busy_nxt      = 1'b0;
    for (int o = 0; o < 4; o++) begin
      w_sel_nxt[o] = r_sel[o];      // selects hold their last value in ARB
      w_rr_nxt[o]  = r_rr_ptr[o];
    end

    case (r_state)
      ST_ARB: begin
        if (|w_gnt_vld) begin
          w_state_nxt = ST_XFER;
          w_busy_nxt  = 1'b1;
          for (int o = 0; o < 4; o++) begin
            if (w_gnt_vld[o]) begin
              w_out_valid_nxt[o]          = 1'b1;
              w_sel_nxt[o]                = {1'b0, w_gnt_idx[o]};
              w_rdreq_nxt[w_gnt_idx[o]]   = 1'b1;
              w_rr_nxt[o]                 = w_gnt_idx[o] + 2'd1;
            end
          end
        end
      end
      ST_XFER: begin
        w_state_nxt = ST_ARB;         // XFER always lasts exactly one cycle
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ARB;
      r_rdreq     <= '0;
      r_out_valid <= '0;
      r_busy      <= 1'b0;
      for (int o = 0; o < 4; o++) begin
        r_sel[o]    <= '0;
        r_rr_ptr[o] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_rdreq     <= w_rdreq_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      for (int o = 0; o < 4; o++) begin
        r_sel[o]    <= w_sel_nxt[o];
        r_rr_ptr[o] <= w_rr_nxt[o];
      end
    end
  end

  assign rdreq     = r_rdreq;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sel0      = r_sel[0];
  assign sel1      = r_sel[1];
  assign sel2      = r_sel[2];
  assign sel3      = r_sel[3];

`ifdef SCHED_STATS_EN
  logic [STAT_W-1:0] r_cnt [4];

  // A cell is counted in the XFER cycle that carries it. A reset landing on
  // that same edge wins, so the counters still come out of reset at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only four registers, so a plain reset of the whole array is
      // cheap; large RAM-style arrays would normally be left unreset.
      for (int o = 0; o < 4; o++) begin
        r_cnt[o] <= '0;
      end
    end else if (r_state == ST_XFER) begin
      for (int o = 0; o < 4; o++) begin
        if (r_out_valid[o] && (r_cnt[o] != {STAT_W{1'b1}})) begin
          r_cnt[o] <= r_cnt[o] + STAT_W'(1);
        end
      end
    end
  end

  assign stat_count = r_cnt[stat_sel];
`endif

endmodule
